// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus between two requesters, the arbiter and the shared ALU.
// The master modport covers everything outside the arbiter: both requesters and the ALU.
interface alu_arbiter_if;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero;
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
        input  alu_result, alu_carry, alu_zero, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_carry, rsp_zero, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
        output alu_result, alu_carry, alu_zero, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_carry, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold).
// Priority flips to the other requester only when a response completes.
// Optional macro ALU_ARBITER_STATS_EN adds saturating 8-bit per-requester grant counters.
module alu_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_arbiter_if.slave    bus
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [7:0]      grant_cnt0,
    output logic [7:0]      grant_cnt1
`endif
);
    localparam logic PRIO_INIT = (RR_INIT != 0);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       grant_id_q, grant_id_d;
    logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
    logic       rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic       busy_q, busy_d;
    logic       gnt0, gnt1, rsp_done;

    // Grant decision: only in IDLE, priority holder wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE) begin
            if (prio_q) begin
                gnt1 = bus.req1_valid;
                gnt0 = bus.req0_valid & ~bus.req1_valid;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid & ~bus.req0_valid;
            end
        end
    end

    assign rsp_done = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    // Next-state and registered-output computation for the IDLE/EXEC/RESP sequence
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        busy_d       = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt0 | gnt1) begin
                    state_d    = S_EXEC;
                    busy_d     = 1'b1;
                    grant_id_d = gnt1;
                    alu_a_d    = gnt1 ? bus.req1_a   : bus.req0_a;
                    alu_b_d    = gnt1 ? bus.req1_b   : bus.req0_b;
                    alu_sel_d  = gnt1 ? bus.req1_sel : bus.req0_sel;
                end
            end
            S_EXEC: begin
                // ALU has had a full cycle on the registered operands
                state_d      = S_RESP;
                rsp_result_d = bus.alu_result;
                rsp_carry_d  = bus.alu_carry;
                rsp_zero_d   = bus.alu_zero;
                rsp0_valid_d = ~grant_id_q;
                rsp1_valid_d = grant_id_q;
            end
            S_RESP: begin
                // Ready from the non-granted requester is ignored via rsp_done
                if (rsp_done) begin
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    prio_d       = ~grant_id_q;
                end
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prio_q       <= PRIO_INIT;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.busy       = busy_q;

`ifdef ALU_ARBITER_STATS_EN
    logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Saturating per-requester accept counters
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0 && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
        if (gnt1 && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses, a monitor pops
// and compares them on each response handshake. ALU stub: 4-bit add with carry/zero.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus();

`ifdef ALU_ARBITER_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    alu_arbiter #(.RR_INIT(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    logic [4:0] sum;
    assign sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_result = sum[3:0];
    assign bus.alu_carry  = sum[4];
    assign bus.alu_zero   = (sum[3:0] == 4'd0);

    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic       c;
        logic       z;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int id);
        return (id != 0) ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic drive(input int id, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel);
        if (id != 0) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
        end
    endtask

    // Offer one operation, push its expected response when accepted
    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input exp_t e);
        @(negedge clk);
        drive(id, 1'b1, a, b, sel);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rdy(id)) begin
                q.push_back(e);
                @(negedge clk);
                drive(id, 1'b0, 4'd0, 4'd0, 3'd0);
                return;
            end
            @(negedge clk);
        end
        chk("issue_timeout", 32'd1, 32'd0);
        drive(id, 1'b0, 4'd0, 4'd0, 3'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (!bus.busy && q.size() == 0) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: compare every completed response against the scoreboard head
    always begin
        exp_t e;
        @(negedge clk); #2;
        if (rst_n) begin
            if (bus.rsp0_valid && bus.rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
            if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", {31'd0, bus.rsp1_valid}, {31'd0, e.id});
                    chk("rsp_result", {28'd0, bus.rsp_result}, {28'd0, e.res});
                    chk("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, e.c});
                    chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.z});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int gid[4];
        int gcyc[4];
        exp_t e0, e1;

        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_carry", bus.rsp_carry, 0);
`ifdef ALU_ARBITER_STATS_EN
        chk("rst_cnt0", grant_cnt0, 0);
`endif
        rst_n = 1'b1;

        // Contention: both valid every cycle, expect 0,1,0,1 every 3 cycles
        e0 = '{id: 1'b0, res: 4'd3, c: 1'b0, z: 1'b0};   // 1+2
        e1 = '{id: 1'b1, res: 4'd0, c: 1'b1, z: 1'b1};   // 15+1
        @(negedge clk);
        drive(0, 1'b1, 4'd1, 4'd2, 3'd0);
        drive(1, 1'b1, 4'd15, 4'd1, 3'd0);
        g = 0;
        for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                chk("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
                gid[g] = bus.req1_ready ? 1 : 0;
                gcyc[g] = cyc;
                q.push_back(bus.req1_ready ? e1 : e0);
                g++;
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
        chk("cont_grants", g, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < g) chk("cont_order", gid[k], k % 2);
            if (k > 0 && k < g) chk("cont_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        wait_idle();

        // Single op with latency probe
        @(negedge clk);
        drive(0, 1'b1, 4'd5, 4'd3, 3'd0);
        #1;
        chk("single_req0_ready", bus.req0_ready, 1);
        chk("single_req1_ready", bus.req1_ready, 0);
        q.push_back('{id: 1'b0, res: 4'd8, c: 1'b0, z: 1'b0});
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        chk("single_exec_busy", bus.busy, 1);
        chk("single_exec_rsp0", bus.rsp0_valid, 0);
        @(negedge clk);
        chk("single_rsp0_valid", bus.rsp0_valid, 1);
        chk("single_rsp1_valid", bus.rsp1_valid, 0);
        chk("single_result", bus.rsp_result, 8);
        wait_idle();

        // Flags: 9+7 wraps to 0 with carry
        issue(1, 4'd9, 4'd7, 3'd0, '{id: 1'b1, res: 4'd0, c: 1'b1, z: 1'b1});
        wait_idle();

        // Backpressure on requester 1 while requester 0 waits
        bus.rsp1_ready = 1'b0;
        issue(1, 4'd6, 4'd4, 3'd2, '{id: 1'b1, res: 4'd10, c: 1'b0, z: 1'b0});
        for (int i = 0; i < 10 && !bus.rsp1_valid; i++) @(negedge clk);
        chk("bp_rsp1_valid_seen", bus.rsp1_valid, 1);
        @(negedge clk);
        drive(0, 1'b1, 4'd2, 4'd2, 3'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_req0_ready", bus.req0_ready, 0);
            chk("bp_rsp1_valid", bus.rsp1_valid, 1);
            chk("bp_rsp_result", bus.rsp_result, 10);
            chk("bp_alu_a", bus.alu_a, 6);
            chk("bp_alu_sel", bus.alu_sel, 2);
            @(negedge clk);
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_grant_after_release", bus.req0_ready, 1);
        if (bus.req0_ready) q.push_back('{id: 1'b0, res: 4'd4, c: 1'b0, z: 1'b0});
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        wait_idle();

        // Reset during EXEC; priority is 1 beforehand, must return to 0
        @(negedge clk);
        drive(0, 1'b1, 4'd1, 4'd1, 3'd0);
        @(posedge clk);
        #2;
        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        chk("rst_exec_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_busy", bus.busy, 0);
        chk("rst_exec_rsp0", bus.rsp0_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("rst_no_rsp", bus.rsp0_valid | bus.busy, 0);
        end
        @(negedge clk);
        drive(0, 1'b1, 4'd4, 4'd4, 3'd0);
        drive(1, 1'b1, 4'd1, 4'd1, 3'd0);
        #1;
        chk("rst_prio_req0", bus.req0_ready, 1);
        chk("rst_prio_req1", bus.req1_ready, 0);
        if (bus.req0_ready) q.push_back('{id: 1'b0, res: 4'd8, c: 1'b0, z: 1'b0});
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
        drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
        wait_idle();

`ifdef ALU_ARBITER_STATS_EN
        // One req0 accept since reset; 300 more must saturate at 255
        chk("stats_cnt0_one", grant_cnt0, 1);
        for (int i = 0; i < 300; i++) begin
            issue(0, 4'd3, 4'd4, 3'd0, '{id: 1'b0, res: 4'd7, c: 1'b0, z: 1'b0});
            wait_idle();
        end
        chk("stats_cnt0_sat", grant_cnt0, 255);
        chk("stats_cnt1", grant_cnt1, 0);
`endif

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
